// File: rtl/verificador_tiros_pkg.sv
// Shared definitions for the shot checker: board geometry and game state encodings.
package verificador_tiros_pkg;
  localparam int NUM_LINHAS  = 5;
  localparam int NUM_COLUNAS = 7;
  localparam int NUM_CELULAS = NUM_LINHAS * NUM_COLUNAS;

  typedef enum logic [1:0] {
    INATIVO = 2'd0,
    JOGANDO = 2'd1,
    VITORIA = 2'd2,
    DERROTA = 2'd3
  } estado_t;

  typedef logic [NUM_CELULAS-1:0] grade_t;

  // Flattened cell index: row-major, column 0 in the LSB of each row.
  function automatic logic [5:0] indice(input logic [2:0] linha, input logic [2:0] coluna);
    return ({3'b000, linha} * 6'd7) + {3'b000, coluna};
  endfunction
endpackage

// File: rtl/verificador_tiros_detector_borda.sv
// Rising-edge detector: one-cycle pulse when the input is high now and was low last cycle.
module detector_borda (
  input  logic clk,
  input  logic reset,
  input  logic sinal,
  output logic subida
);
  logic ant_d;
  logic ant_q;

  always_comb ant_d = sinal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ant_q <= 1'b0;
    else       ant_q <= ant_d;
  end

  assign subida = sinal & ~ant_q;
endmodule

// File: rtl/verificador_tiros.sv
// Battleship shot checker: latches the ship map at game start, scores each fire-button edge
// with a one-cycle result pulse, tracks shots left and ends the game in victory or defeat.
module verificador_tiros
  import verificador_tiros_pkg::*;
#(
  parameter int MAX_TIROS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  input  logic [2:0] linha,
  input  logic [2:0] coluna,
  input  logic       atirar,
  output logic [6:0] acertos0,
  output logic [6:0] acertos1,
  output logic [6:0] acertos2,
  output logic [6:0] acertos3,
  output logic [6:0] acertos4,
  output logic [6:0] tiros0,
  output logic [6:0] tiros1,
  output logic [6:0] tiros2,
  output logic [6:0] tiros3,
  output logic [6:0] tiros4,
  output logic [4:0] tiros_restantes,
  output logic       acerto,
  output logic       erro,
  output logic       repetido,
  output logic       invalido,
  output logic       vitoria,
  output logic       derrota
);
  logic   enable_sobe;
  logic   tiro_sobe;
  grade_t mapa_in;
  logic [5:0] pos;

  estado_t    estado_d, estado_q;
  grade_t     mapa_d, mapa_q;
  grade_t     acertos_d, acertos_q;
  grade_t     tiros_d, tiros_q;
  logic [4:0] restantes_d, restantes_q;
  logic       acerto_d, acerto_q;
  logic       erro_d, erro_q;
  logic       repetido_d, repetido_q;
  logic       invalido_d, invalido_q;

  detector_borda u_borda_enable (.clk(clk), .reset(reset), .sinal(enable), .subida(enable_sobe));
  detector_borda u_borda_atirar (.clk(clk), .reset(reset), .sinal(atirar), .subida(tiro_sobe));

  assign mapa_in = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign pos     = indice(linha, coluna);

  always_comb begin
    estado_d    = estado_q;
    mapa_d      = mapa_q;
    acertos_d   = acertos_q;
    tiros_d     = tiros_q;
    restantes_d = restantes_q;
    acerto_d    = 1'b0;
    erro_d      = 1'b0;
    repetido_d  = 1'b0;
    invalido_d  = 1'b0;

    // Dropping enable ends any game; the board outputs keep their last values.
    if (!enable) begin
      estado_d = INATIVO;
    end else begin
      case (estado_q)
        INATIVO: begin
          if (enable_sobe) begin
            mapa_d      = mapa_in;
            acertos_d   = '0;
            tiros_d     = '0;
            restantes_d = 5'(MAX_TIROS);
            estado_d    = (mapa_in == '0) ? VITORIA : JOGANDO;
          end
        end
        JOGANDO: begin
          if (tiro_sobe) begin
            if (linha > 3'd4 || coluna > 3'd6) begin
              invalido_d = 1'b1;
            end else if (tiros_q[pos]) begin
              repetido_d = 1'b1;
            end else begin
              tiros_d[pos] = 1'b1;
              restantes_d  = restantes_q - 5'd1;
              if (mapa_q[pos]) begin
                acertos_d[pos] = 1'b1;
                acerto_d       = 1'b1;
              end else begin
                erro_d = 1'b1;
              end
              // Sinking the last ship wins even if it was the last shot.
              if (acertos_d == mapa_q)   estado_d = VITORIA;
              else if (restantes_d == '0) estado_d = DERROTA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= INATIVO;
      mapa_q      <= '0;
      acertos_q   <= '0;
      tiros_q     <= '0;
      restantes_q <= '0;
      acerto_q    <= 1'b0;
      erro_q      <= 1'b0;
      repetido_q  <= 1'b0;
      invalido_q  <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      mapa_q      <= mapa_d;
      acertos_q   <= acertos_d;
      tiros_q     <= tiros_d;
      restantes_q <= restantes_d;
      acerto_q    <= acerto_d;
      erro_q      <= erro_d;
      repetido_q  <= repetido_d;
      invalido_q  <= invalido_d;
    end
  end

  assign acertos0 = acertos_q[6:0];
  assign acertos1 = acertos_q[13:7];
  assign acertos2 = acertos_q[20:14];
  assign acertos3 = acertos_q[27:21];
  assign acertos4 = acertos_q[34:28];
  assign tiros0   = tiros_q[6:0];
  assign tiros1   = tiros_q[13:7];
  assign tiros2   = tiros_q[20:14];
  assign tiros3   = tiros_q[27:21];
  assign tiros4   = tiros_q[34:28];

  assign tiros_restantes = restantes_q;
  assign acerto          = acerto_q;
  assign erro            = erro_q;
  assign repetido        = repetido_q;
  assign invalido        = invalido_q;
  assign vitoria         = (estado_q == VITORIA);
  assign derrota         = (estado_q == DERROTA);
endmodule
